fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage that sits directly upstream of the decode pipeline register. It owns the PC, issues requests on the instruction bus, and presents one registered {valid, pc, instr} bundle per cycle to decode. It honours a stall from the hazard unit and a flush/redirect from execute, including a redirect that arrives while a bus request is still outstanding.

## Interface
- RESET_PC, 64'h8000_0000, first fetch address after reset
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- ireq_valid  out  1  instruction request valid
- ireq_addr  out  64  request address; held stable while ireq_valid=1 until iresp_data_ok
- iresp_data_ok  in  1  response for current request is valid this cycle
- iresp_data  in  32  instruction word, valid when iresp_data_ok=1
- stall  in  1  decode cannot accept a new bundle; output registers hold
- flush  in  1  discard everything in flight and refetch from redirect_pc
- redirect_pc  in  64  new fetch address, sampled when flush=1
- out_valid  out  1  bundle to decode is a real instruction
- out_pc  out  64  PC of out_instr
- out_instr  out  32  fetched instruction

## Operation
- State: addr_q (64), redirect_q (64), buf_q (32), state ∈ {FETCH, HOLD, DISCARD}.
- ireq_valid = (state==FETCH || state==DISCARD) && !reset; ireq_addr = addr_q.
- FETCH:
  - data_ok & flush: drop word; addr_q<=redirect_pc; out_valid<=0; stay FETCH.
  - data_ok & !flush & !stall: out_valid<=1, out_pc<=addr_q, out_instr<=iresp_data; addr_q<=addr_q+4; stay.
  - data_ok & !flush & stall: buf_q<=iresp_data; addr_q<=addr_q+4; outputs hold; ->HOLD.
  - !data_ok & flush: redirect_q<=redirect_pc; out_valid<=0; ->DISCARD (request at old addr must complete).
  - !data_ok & !flush: out_valid<=0 if !stall (bubble), else hold.
- HOLD (no request issued):
  - flush: drop buf_q; addr_q<=redirect_pc; out_valid<=0; ->FETCH.
  - !stall: out_valid<=1, out_pc<=addr_q-4, out_instr<=buf_q; ->FETCH.
  - stall: hold.
- DISCARD (request still asserted at stale addr_q):
  - flush again: redirect_q<=redirect_pc (latest wins).
  - data_ok: drop word; addr_q<=(flush ? redirect_pc : redirect_q); ->FETCH.
  - out_valid stays 0 throughout.
- Flush beats stall everywhere: flush always forces out_valid<=0.
- PC arithmetic: 64-bit, +4 wraps modulo 2^64; low two bits are not checked or masked.

## Timing
- Reset (synchronous): state=FETCH, addr_q=RESET_PC, redirect_q=0, buf_q=0, out_valid=0, out_pc=0, out_instr=0; ireq_valid=0 during reset cycle.
- First request: cycle after reset deasserts, ireq_valid=1, ireq_addr=RESET_PC.
- Latency: data_ok in cycle N -> bundle on outputs in N+1.
- Throughput: 1 instr/cycle with zero-wait memory (data_ok same cycle as request).
- Stall release from HOLD: bundle appears the cycle after stall falls; new request issues in that same cycle.
- Redirect latency: flush in FETCH/HOLD -> ireq_addr=redirect_pc next cycle; flush in DISCARD-pending -> ireq_addr=redirect target the cycle after the stale data_ok.
- Reset mid-request/HOLD/DISCARD: all state cleared as above; stale response is not tracked.

## Test plan
- Zero-wait stream: data_ok tied 1, data=pc[31:0] -> out_pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, out_valid=1 from cycle 2 after reset.
- Wait states: data_ok every 3rd cycle -> out_valid pulses 1 for one cycle per word, 0 bubbles between, PCs strictly +4.
- Stall with data_ok: stall high 3 cycles while word at 0x80000008 returns -> outputs frozen, ireq_valid=0 in HOLD; on release out_pc=0x80000008, next ireq_addr=0x8000000C.
- Flush mid-request: request at 0x80000010 with no data_ok, flush to 0x80001000 -> ireq_addr stays 0x80000010 until data_ok, word dropped (out_valid=0), next ireq_addr=0x80001000.
- Flush in HOLD and double flush in DISCARD (0x2000 then 0x3000) -> buffered word dropped; fetch resumes at 0x3000.
- Reset asserted in DISCARD -> next cycle ireq_addr=RESET_PC, out_valid=0, old redirect ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction bus and hands one
// registered {valid, pc, instr} bundle per cycle to decode, honouring stall and redirect.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        flush,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  fetchState_t state, stateNext;
  logic [63:0] addrQ, addrNext;
  logic [63:0] redirectQ, redirectNext;
  logic [31:0] bufQ, bufNext;
  logic        validNext;
  logic [63:0] pcNext;
  logic [31:0] instrNext;

  assign ireq_valid = ((state == FETCH) || (state == DISCARD)) && !reset;
  assign ireq_addr  = addrQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      addrQ     <= RESET_PC;
      redirectQ <= '0;
      bufQ      <= '0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
    end else begin
      state     <= stateNext;
      addrQ     <= addrNext;
      redirectQ <= redirectNext;
      bufQ      <= bufNext;
      out_valid <= validNext;
      out_pc    <= pcNext;
      out_instr <= instrNext;
    end
  end

  always_comb begin
    stateNext    = state;
    addrNext     = addrQ;
    redirectNext = redirectQ;
    bufNext      = bufQ;
    validNext    = out_valid;
    pcNext       = out_pc;
    instrNext    = out_instr;
    unique case (state)
      FETCH: begin
        if (iresp_data_ok) begin
          if (flush) begin
            addrNext  = redirect_pc;
            validNext = 1'b0;
          end else if (!stall) begin
            validNext = 1'b1;
            pcNext    = addrQ;
            instrNext = iresp_data;
            addrNext  = addrQ + 64'd4;
          end else begin
            // Decode is busy: park the word so the bus can be released.
            bufNext   = iresp_data;
            addrNext  = addrQ + 64'd4;
            stateNext = HOLD;
          end
        end else if (flush) begin
          // The bus request at the old address must still complete before redirecting.
          redirectNext = redirect_pc;
          validNext    = 1'b0;
          stateNext    = DISCARD;
        end else if (!stall) begin
          validNext = 1'b0;
        end
      end
      HOLD: begin
        if (flush) begin
          addrNext  = redirect_pc;
          validNext = 1'b0;
          stateNext = FETCH;
        end else if (!stall) begin
          validNext = 1'b1;
          pcNext    = addrQ - 64'd4;
          instrNext = bufQ;
          stateNext = FETCH;
        end
      end
      DISCARD: begin
        validNext = 1'b0;
        if (flush) redirectNext = redirect_pc;
        if (iresp_data_ok) begin
          addrNext  = flush ? redirect_pc : redirectQ;
          stateNext = FETCH;
        end
      end
      default: stateNext = FETCH;
    endcase
  end

endmodule
